// File: rtl/grid_map_if.sv
// Bus bundle for grid_map: cell-write port, sweep-clear control, pixel lookup and robot status.
interface grid_map_if;
  logic       WR_EN;
  logic [7:0] WR_COORD;
  logic [1:0] WR_VALUE;
  logic       CLEAR;
  logic [9:0] PIXEL_X;
  logic [9:0] PIXEL_Y;
  logic       PIXEL_VALID;
  logic [7:0] PIXEL_COLOR;
  logic       COLOR_VALID;
  logic       BUSY;
  logic       WR_ERR;
  logic [7:0] ROBOT_COORD;
  logic       ROBOT_VLD;

  modport master (
    output WR_EN, WR_COORD, WR_VALUE, CLEAR, PIXEL_X, PIXEL_Y, PIXEL_VALID,
    input  PIXEL_COLOR, COLOR_VALID, BUSY, WR_ERR, ROBOT_COORD, ROBOT_VLD
  );

  modport slave (
    input  WR_EN, WR_COORD, WR_VALUE, CLEAR, PIXEL_X, PIXEL_Y, PIXEL_VALID,
    output PIXEL_COLOR, COLOR_VALID, BUSY, WR_ERR, ROBOT_COORD, ROBOT_VLD
  );
endinterface

// File: rtl/grid_map.sv
// Maze-state store: cell writes, robot tracking, sweep-clear and a 2-stage pixel colour lookup.
// Optional cell-border overlay enabled by defining GRID_MAP_LINES_EN.
module grid_map #(
  parameter int unsigned GRID_W     = 4,
  parameter int unsigned GRID_H     = 5,
  parameter int unsigned CELL_SHIFT = 6,
  parameter int unsigned X0         = 64,
  parameter int unsigned Y0         = 40
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  grid_map_if.slave  bus
);

  localparam int unsigned N_CELLS = GRID_W * GRID_H;
  localparam int unsigned IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int unsigned D_W     = 11;
  localparam logic signed [D_W:0] LIM_X = 12'(GRID_W << CELL_SHIFT);
  localparam logic signed [D_W:0] LIM_Y = 12'(GRID_H << CELL_SHIFT);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_CELLS - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_CLEARING} state_t;

  state_t                 r_state;
  logic [1:0]             r_cell [N_CELLS];
  logic [IDX_W-1:0]       r_clr_idx;
  logic                   r_busy;
  logic                   r_wr_err;
  logic [7:0]             r_robot_coord;
  logic                   r_robot_vld;
  logic                   r_v1;
  logic signed [D_W-1:0]  r_dx;
  logic signed [D_W-1:0]  r_dy;
  logic                   r_ingrid;
  logic                   r_cvalid;
  logic [7:0]             r_color;

  logic [31:0]            w_wr_lin;
  logic [31:0]            w_rb_lin;
  logic [31:0]            w_rd_lin;
  logic [IDX_W-1:0]       w_wr_idx;
  logic [IDX_W-1:0]       w_rb_idx;
  logic [IDX_W-1:0]       w_rd_idx;
  logic                   w_wr_ok;
  logic signed [D_W-1:0]  w_dx;
  logic signed [D_W-1:0]  w_dy;
  logic                   w_ingrid;
  logic [1:0]             w_rd_val;
  logic                   w_border;
  logic [7:0]             w_color;

  function automatic logic [7:0] cell_color(input logic [1:0] v);
    case (v)
      2'd0:    cell_color = 8'h49;
      2'd1:    cell_color = 8'h1C;
      2'd2:    cell_color = 8'hE0;
      default: cell_color = 8'h03;
    endcase
  endfunction

  // Clear request and busy sweep both shadow the write port
  assign w_wr_lin = 32'(bus.WR_COORD[3:0]) * GRID_W + 32'(bus.WR_COORD[7:4]);
  assign w_rb_lin = 32'(r_robot_coord[3:0]) * GRID_W + 32'(r_robot_coord[7:4]);
  assign w_wr_idx = IDX_W'(w_wr_lin);
  assign w_rb_idx = IDX_W'(w_rb_lin);
  assign w_wr_ok  = bus.WR_EN && !r_busy && !bus.CLEAR &&
                    (32'(bus.WR_COORD[7:4]) < GRID_W) && (32'(bus.WR_COORD[3:0]) < GRID_H);

  assign w_dx     = $signed({1'b0, bus.PIXEL_X}) - $signed(11'(X0));
  assign w_dy     = $signed({1'b0, bus.PIXEL_Y}) - $signed(11'(Y0));
  assign w_ingrid = !w_dx[D_W-1] && ($signed({w_dx[D_W-1], w_dx}) < LIM_X) &&
                    !w_dy[D_W-1] && ($signed({w_dy[D_W-1], w_dy}) < LIM_Y);

  assign w_rd_lin = 32'(unsigned'(r_dy) >> CELL_SHIFT) * GRID_W + 32'(unsigned'(r_dx) >> CELL_SHIFT);
  assign w_rd_idx = IDX_W'(w_rd_lin);
  assign w_rd_val = (w_rd_lin < N_CELLS) ? r_cell[w_rd_idx] : 2'd0;

`ifdef GRID_MAP_LINES_EN
  assign w_border = r_ingrid && ((r_dx[CELL_SHIFT-1:0] == '0) || (r_dy[CELL_SHIFT-1:0] == '0));
`else
  assign w_border = 1'b0;
`endif

  assign w_color = !r_ingrid ? 8'h00 : (w_border ? 8'hFF : cell_color(w_rd_val));

  // Map state, sweep-clear FSM, robot tracking and lookup pipeline
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      for (int i = 0; i < int'(N_CELLS); i++) r_cell[i] <= 2'd0;
      r_clr_idx     <= '0;
      r_busy        <= 1'b0;
      r_wr_err      <= 1'b0;
      r_robot_coord <= 8'h00;
      r_robot_vld   <= 1'b0;
      r_v1          <= 1'b0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_ingrid      <= 1'b0;
      r_cvalid      <= 1'b0;
      r_color       <= 8'h00;
    end else begin
      r_wr_err <= bus.WR_EN && !w_wr_ok;

      case (r_state)
        ST_IDLE: begin
          if (bus.CLEAR) begin
            r_state     <= ST_CLEARING;
            r_clr_idx   <= '0;
            r_busy      <= 1'b1;
            r_robot_vld <= 1'b0;
          end
        end
        ST_CLEARING: begin
          if (bus.CLEAR) begin
            r_clr_idx <= '0;
          end else begin
            r_cell[r_clr_idx] <= 2'd0;
            if (r_clr_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_clr_idx <= r_clr_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Only reachable in IDLE without a clear request, so never races the sweep
      if (w_wr_ok) begin
        r_cell[w_wr_idx] <= bus.WR_VALUE;
        if (bus.WR_VALUE == 2'd3) begin
          if (r_robot_vld && (r_robot_coord != bus.WR_COORD)) r_cell[w_rb_idx] <= 2'd1;
          r_robot_coord <= bus.WR_COORD;
          r_robot_vld   <= 1'b1;
        end else if (bus.WR_COORD == r_robot_coord) begin
          r_robot_vld <= 1'b0;
        end
      end

      r_v1 <= bus.PIXEL_VALID;
      if (bus.PIXEL_VALID) begin
        r_dx     <= w_dx;
        r_dy     <= w_dy;
        r_ingrid <= w_ingrid;
      end
      r_cvalid <= r_v1;
      if (r_v1) r_color <= w_color;
    end
  end

  assign bus.PIXEL_COLOR = r_color;
  assign bus.COLOR_VALID = r_cvalid;
  assign bus.BUSY        = r_busy;
  assign bus.WR_ERR      = r_wr_err;
  assign bus.ROBOT_COORD = r_robot_coord;
  assign bus.ROBOT_VLD   = r_robot_vld;

endmodule

// File: tb/tb_grid_map.sv
// Scoreboard bench for grid_map: stimulus queues expected colours, a monitor pops on COLOR_VALID.
module tb_grid_map;

  typedef struct {
    logic [7:0] col;
    bit         chk;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];
  logic pv_d1, pv_d2;
  logic [7:0] last_col;
  bit   last_known;

  grid_map_if bus ();

  grid_map dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for COLOR_VALID: PIXEL_VALID delayed two edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_d1 <= 1'b0;
      pv_d2 <= 1'b0;
    end else begin
      pv_d1 <= bus.PIXEL_VALID;
      pv_d2 <= pv_d1;
    end
  end

  // Monitor: samples on the falling edge, pops one expectation per valid colour
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      last_col   = 8'h00;
      last_known = 1'b1;
    end else begin
      total++;
      if (bus.COLOR_VALID !== pv_d2) begin
        bad++;
        $display("FAIL color_valid_delay: got %b want %b at %0t", bus.COLOR_VALID, pv_d2, $time);
      end
      if (bus.COLOR_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_color: got %h with empty scoreboard at %0t", bus.PIXEL_COLOR, $time);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            total++;
            if (bus.PIXEL_COLOR !== e.col) begin
              bad++;
              $display("FAIL pixel_color: got %h want %h at %0t", bus.PIXEL_COLOR, e.col, $time);
            end
            last_col   = e.col;
            last_known = 1'b1;
          end else begin
            last_known = 1'b0;
          end
        end
      end else if (last_known) begin
        total++;
        if (bus.PIXEL_COLOR !== last_col) begin
          bad++;
          $display("FAIL color_hold: got %h want %h at %0t", bus.PIXEL_COLOR, last_col, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [7:0] coord, input logic [1:0] val);
    bus.WR_EN    = 1'b1;
    bus.WR_COORD = coord;
    bus.WR_VALUE = val;
    tick();
    bus.WR_EN    = 1'b0;
  endtask

  task automatic push(input logic [7:0] col, input bit chk);
    exp_t e;
    e.col = col;
    e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic px(input int x, input int y, input logic [7:0] col);
    bus.PIXEL_VALID = 1'b1;
    bus.PIXEL_X     = 10'(x);
    bus.PIXEL_Y     = 10'(y);
    push(col, 1'b1);
    tick();
    bus.PIXEL_VALID = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] border_exp;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.WR_EN = 1'b0; bus.WR_COORD = '0; bus.WR_VALUE = '0; bus.CLEAR = 1'b0;
    bus.PIXEL_X = '0; bus.PIXEL_Y = '0; bus.PIXEL_VALID = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_color",  bus.PIXEL_COLOR, 8'h00);
    check("rst_cvalid", 8'(bus.COLOR_VALID), 8'h00);
    check("rst_busy",   8'(bus.BUSY), 8'h00);
    check("rst_wr_err", 8'(bus.WR_ERR), 8'h00);
    check("rst_robot",  bus.ROBOT_COORD, 8'h00);
    check("rst_rvld",   8'(bus.ROBOT_VLD), 8'h00);

    // Wall at (1,2), then lookups inside and outside the grid
    wr(8'h12, 2'd2);
    check("good_wr_err", 8'(bus.WR_ERR), 8'h00);
    px(138, 173, 8'hE0);
    px(10, 10, 8'h00);
    px(70, 50, 8'h49);
    drain();

    // Robot moves from (0,0) to (3,4); old cell becomes explored
    wr(8'h00, 2'd3);
    check("robot_first", bus.ROBOT_COORD, 8'h00);
    check("rvld_first",  8'(bus.ROBOT_VLD), 8'h01);
    wr(8'h34, 2'd3);
    check("robot_move", bus.ROBOT_COORD, 8'h34);
    check("rvld_move",  8'(bus.ROBOT_VLD), 8'h01);
    px(70, 50, 8'h1C);
    px(270, 310, 8'h03);
    drain();

    // Out-of-range column
    wr(8'h40, 2'd2);
    check("oor_wr_err", 8'(bus.WR_ERR), 8'h01);
    tick();
    check("oor_wr_err_pulse", 8'(bus.WR_ERR), 8'h00);
    check("oor_robot", bus.ROBOT_COORD, 8'h34);
    check("oor_rvld",  8'(bus.ROBOT_VLD), 8'h01);
    px(138, 173, 8'hE0);
    px(70, 40, 8'h1C);
    drain();

    // Non-robot value over the robot cell drops tracking
    wr(8'h34, 2'd1);
    check("overwrite_rvld", 8'(bus.ROBOT_VLD), 8'h00);

    // Fill with explored, re-place the robot, then sweep-clear
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 4; x++)
        wr(8'((x << 4) | y), 2'd1);
    px(266, 306, 8'h1C);
    wr(8'h34, 2'd3);
    check("refill_rvld", 8'(bus.ROBOT_VLD), 8'h01);
    drain();

    bus.CLEAR = 1'b1;
    tick();
    bus.CLEAR = 1'b0;
    check("clear_rvld", 8'(bus.ROBOT_VLD), 8'h00);
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.BUSY !== 1'b1) break;
      busy_cnt++;
      if (busy_cnt == 4) check("busy_wr_err", 8'(bus.WR_ERR), 8'h01);
      if (busy_cnt == 3) begin
        bus.WR_EN = 1'b1; bus.WR_COORD = 8'h00; bus.WR_VALUE = 2'd2;
      end else begin
        bus.WR_EN = 1'b0;
      end
      tick();
    end
    bus.WR_EN = 1'b0;
    check("busy_cycles", 8'(busy_cnt), 8'd20);
    check("post_clear_rvld", 8'(bus.ROBOT_VLD), 8'h00);

    // Every cell after the sweep, back-to-back
    for (int cy = 0; cy < 5; cy++)
      for (int cx = 0; cx < 4; cx++) begin
        bus.PIXEL_VALID = 1'b1;
        bus.PIXEL_X = 10'(64 + 32 + 64 * cx);
        bus.PIXEL_Y = 10'(40 + 32 + 64 * cy);
        push(8'h49, 1'b1);
        tick();
      end
    bus.PIXEL_VALID = 1'b0;
    drain();

    // Continuous stream through cell (2,1) with a write landing on pixel 5's edge
    for (int i = 0; i < 12; i++) begin
      bus.PIXEL_VALID = 1'b1;
      bus.PIXEL_X = 10'(200 + i);
      bus.PIXEL_Y = 10'd110;
      bus.WR_EN    = (i == 5);
      bus.WR_COORD = 8'h21;
      bus.WR_VALUE = 2'd2;
      if (i < 4)       push(8'h49, 1'b1);
      else if (i == 4) push(8'h00, 1'b0);
      else             push(8'hE0, 1'b1);
      tick();
    end
    bus.WR_EN = 1'b0;
    bus.PIXEL_VALID = 1'b0;
    drain();

    // Border pixel vs. interior pixel of cell (1,0)
`ifdef GRID_MAP_LINES_EN
    border_exp = 8'hFF;
`else
    border_exp = 8'h49;
`endif
    px(128, 40, border_exp);
    px(129, 41, 8'h49);
    drain();

    // Reset in the middle of a stream with a live robot
    wr(8'h11, 2'd3);
    for (int i = 0; i < 4; i++) begin
      bus.PIXEL_VALID = 1'b1;
      bus.PIXEL_X = 10'(200 + i);
      bus.PIXEL_Y = 10'd110;
      push(8'hE0, 1'b1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_color",  bus.PIXEL_COLOR, 8'h00);
    check("mid_rst_cvalid", 8'(bus.COLOR_VALID), 8'h00);
    check("mid_rst_rvld",   8'(bus.ROBOT_VLD), 8'h00);
    check("mid_rst_robot",  bus.ROBOT_COORD, 8'h00);
    check("mid_rst_busy",   8'(bus.BUSY), 8'h00);
    bus.PIXEL_VALID = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    px(200, 110, 8'h49);
    px(70, 50, 8'h49);
    drain();

    check("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
